queue_arbiter: RTL

Round-robin arbiter that shares one relational-cache `Queue` instance between `NUM_REQ` producers and sequences its consumer side. It grants at most one push per cycle and registers the granted word into the queue. It keeps a shadow occupancy count that includes in-flight pushes, so it never overfills the queue. It also drives the queue's `consumed` strobe from a downstream ready and supports a flush that drains the queue.

---
 rtl/queue_arbiter_pkg.sv | 35 +++
 rtl/queue_arbiter_if.sv | 40 ++++
 rtl/queue_arbiter_rr_pick.sv | 36 +++
 rtl/queue_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/queue_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_arbiter_pkg
// Description : Shared types and helpers for the queue arbiter slice:
//               FSM state encoding, rr_pick width limits, index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_arbiter_pkg;

  // Arbiter FSM states; LOCK is only reachable when QUEUE_ARB_LOCK_EN is set
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Supported producer counts for the rotate-priority picker
  localparam int c_RR_MIN_REQ = 2;
  localparam int c_RR_MAX_REQ = 8;

  // Index width for a picker of n inputs, clamped to the supported range
  function automatic int rrIdxWidth(input int n);
    int lim;
    lim = (n < c_RR_MIN_REQ) ? c_RR_MIN_REQ :
          (n > c_RR_MAX_REQ) ? c_RR_MAX_REQ : n;
    return $clog2(lim);
  endfunction

  // Position `off` steps after `base`, wrapping modulo n
  function automatic int rrWrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/queue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : queue_arbiter_if
// Description : Producer, queue and downstream signals of the queue arbiter.
//               slave  = arbiter side, master = everything around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface queue_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_SIZE    = 8,
  parameter int QUEUE_LENGTH = 4
);
  localparam int OCC_W = $clog2(QUEUE_LENGTH + 1);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_SIZE-1:0] reqData;
  logic [NUM_REQ-1:0]           reqLock;
  logic [NUM_REQ-1:0]           ack;
  logic                         flush;
  logic                         flushBusy;
  logic [DATA_SIZE-1:0]         qValueIn;
  logic                         qValueInValid;
  logic                         qConsumed;
  logic                         qEmpty;
  logic                         outReady;
  logic                         outValid;
  logic [OCC_W-1:0]             occupancy;

  modport slave (
    input  req, reqData, reqLock, flush, qEmpty, outReady,
    output ack, flushBusy, qValueIn, qValueInValid, qConsumed, outValid, occupancy
  );

  modport master (
    output req, reqData, reqLock, flush, qEmpty, outReady,
    input  ack, flushBusy, qValueIn, qValueInValid, qConsumed, outValid, occupancy
  );

endinterface
`default_nettype wire

// File: rtl/queue_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority picker. Returns the first
//               requester at or after `pointer`, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import queue_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scan from the pointer and keep the first hit
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[rrWrap(int'(pointer), i, N)]) begin
        any                              = 1'b1;
        grant[rrWrap(int'(pointer), i, N)] = 1'b1;
        index                            = IDX_W'(rrWrap(int'(pointer), i, N));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : queue_arbiter
// Description : Round-robin push arbiter in front of a shared Queue. Grants
//               one producer per cycle, registers the word into the queue,
//               tracks a shadow occupancy (in-flight pushes included), drives
//               the consume strobe and drains the queue on flush.
//               Optional feature macro: QUEUE_ARB_LOCK_EN (grant locking).
// Revision    : 1.0 - initial release
// ============================================================================
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_SIZE    = 8,
  parameter int QUEUE_LENGTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  queue_arbiter_if.slave  bus
);

  localparam int OCC_W = $clog2(QUEUE_LENGTH + 1);
  localparam int IDX_W = rrIdxWidth(NUM_REQ);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_pointer;
  logic [OCC_W-1:0]       r_occupancy;
  logic [DATA_SIZE-1:0]   r_qValueIn;
  logic                   r_qValueInValid;
  logic                   r_flushBusy;
`ifdef QUEUE_ARB_LOCK_EN
  logic [IDX_W-1:0]       r_lockIdx;
`endif

  logic [NUM_REQ-1:0]     w_pickReq;
  logic [IDX_W-1:0]       w_pickPtr;
  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_space;
  logic                   w_push;
  logic                   w_outValid;
  logic                   w_consume;
  logic [DATA_SIZE-1:0]   w_word;
  logic [IDX_W-1:0]       w_nextPtr;

  // A consume in this cycle does not free space until the count updates
  assign w_space = (r_occupancy < OCC_W'(QUEUE_LENGTH));

  // Select which requests compete: all in ARB, only the locked one in LOCK
  always_comb begin
    w_pickReq = '0;
    w_pickPtr = r_pointer;
    case (r_state)
      ARB: w_pickReq = bus.req;
`ifdef QUEUE_ARB_LOCK_EN
      LOCK: begin
        w_pickReq = bus.req & (NUM_REQ'(1) << r_lockIdx);
        w_pickPtr = r_lockIdx;
      end
`endif
      default: w_pickReq = '0;
    endcase
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rrPick (
    .req     (w_pickReq),
    .pointer (w_pickPtr),
    .grant   (w_grant),
    .index   (w_idx),
    .any     (w_any)
  );

  // Reset gating keeps the combinational strobes quiet while reset is held
  assign w_push     = reset & w_space & w_any;
  assign w_outValid = reset & (r_state != FLUSH) & ~bus.qEmpty;
  assign w_consume  = reset & ((r_state == FLUSH) ? ~bus.qEmpty
                                                  : (w_outValid & bus.outReady));
  assign w_word     = bus.reqData[w_idx*DATA_SIZE +: DATA_SIZE];
  assign w_nextPtr  = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // FSM, push register, pointer and shadow occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= ARB;
      r_pointer       <= '0;
      r_occupancy     <= '0;
      r_qValueIn      <= '0;
      r_qValueInValid <= 1'b0;
      r_flushBusy     <= 1'b0;
`ifdef QUEUE_ARB_LOCK_EN
      r_lockIdx       <= '0;
`endif
    end else begin
      r_qValueInValid <= w_push;
      if (w_push) begin
        r_qValueIn <= w_word;
        // In LOCK the index is the locked producer, so this already holds g+1
        r_pointer  <= w_nextPtr;
      end

      case ({w_push, w_consume})
        2'b10: r_occupancy <= r_occupancy + 1'b1;
        2'b01: if (r_occupancy != '0) r_occupancy <= r_occupancy - 1'b1;
        default: r_occupancy <= r_occupancy;
      endcase

      case (r_state)
        ARB: begin
          if (bus.flush) begin
            r_state     <= FLUSH;
            r_flushBusy <= 1'b1;
          end
`ifdef QUEUE_ARB_LOCK_EN
          else if (w_push && bus.reqLock[w_idx]) begin
            r_state   <= LOCK;
            r_lockIdx <= w_idx;
          end
`endif
        end
`ifdef QUEUE_ARB_LOCK_EN
        LOCK: begin
          if (bus.flush) begin
            r_state     <= FLUSH;
            r_flushBusy <= 1'b1;
          end else if (!bus.req[r_lockIdx] ||
                       (w_push && !bus.reqLock[r_lockIdx])) begin
            r_state <= ARB;
          end
        end
`endif
        FLUSH: begin
          // Leave once nothing is stored or in flight; flush pulses are ignored
          if (r_occupancy == '0 && !r_qValueInValid) begin
            r_state     <= ARB;
            r_flushBusy <= 1'b0;
          end
        end
        default: begin
          r_state     <= ARB;
          r_flushBusy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack           = w_grant & {NUM_REQ{w_push}};
  assign bus.flushBusy     = r_flushBusy;
  assign bus.qValueIn      = r_qValueIn;
  assign bus.qValueInValid = r_qValueInValid;
  assign bus.qConsumed     = w_consume;
  assign bus.outValid      = w_outValid;
  assign bus.occupancy     = r_occupancy;

endmodule
`default_nettype wire
